// File: rtl/tc0100scn_rom_fetch.sv
// Toggle-handshake graphics ROM responder: one 32-bit tile-row fetch as two 16-bit arbiter reads.
// Optional single-entry fetch cache enabled by defining TC0100SCN_ROM_CACHE_EN.
module tc0100scn_rom_fetch #(
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rom_address,
  input  logic              rom_req,
  output logic [31:0]       rom_data,
  output logic              rom_ack,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_req,
  input  logic [15:0]       mem_data,
  input  logic              mem_ack,
  input  logic              cache_inval
);

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, DONE} state_t;

  state_t      state;
  logic        req_seen;
  logic [15:0] lo;
  logic [15:0] hi;
  logic        pending;

  assign pending = (rom_req != req_seen);

`ifdef TC0100SCN_ROM_CACHE_EN
  logic              cache_valid;
  logic [ADDR_W-1:2] cache_tag;
  logic [31:0]       cache_data;
  logic [ADDR_W-1:2] cur_a;
  logic              hit_r;
  logic              fill_ok;
  logic              hit;
  logic [1:0]        unused_addr_lsb;

  // An invalidate on the detect edge wins over a stale tag match.
  assign hit = cache_valid && !cache_inval && (cache_tag == rom_address[ADDR_W-1:2]);
  assign unused_addr_lsb = rom_address[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_seen    <= 1'b0;
      rom_data    <= '0;
      rom_ack     <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      lo          <= '0;
      hi          <= '0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      cur_a       <= '0;
      hit_r       <= 1'b0;
      fill_ok     <= 1'b0;
    end else begin
      if (cache_inval) begin
        cache_valid <= 1'b0;
        fill_ok     <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (pending) begin
            req_seen <= rom_req;
            cur_a    <= rom_address[ADDR_W-1:2];
            fill_ok  <= !cache_inval;
            hit_r    <= hit;
            if (hit) begin
              state <= DONE;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= {rom_address[ADDR_W-1:2], 1'b0};
              state    <= RD_LO;
            end
          end
        end
        RD_LO: begin
          if (mem_ack) begin
            lo          <= mem_data;
            mem_addr[0] <= 1'b1;
            state       <= RD_HI;
          end
        end
        RD_HI: begin
          if (mem_ack) begin
            hi      <= mem_data;
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          rom_data <= hit_r ? cache_data : {hi, lo};
          rom_ack  <= req_seen;
          // A fetch overlapped by an invalidate returns memory data but is not kept.
          if (!hit_r && fill_ok && !cache_inval) begin
            cache_valid <= 1'b1;
            cache_tag   <= cur_a;
            cache_data  <= {hi, lo};
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic [2:0] unused_inputs;

  assign unused_inputs = {rom_address[1:0], cache_inval};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_seen <= 1'b0;
      rom_data <= '0;
      rom_ack  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      lo       <= '0;
      hi       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending) begin
            req_seen <= rom_req;
            mem_req  <= 1'b1;
            mem_addr <= {rom_address[ADDR_W-1:2], 1'b0};
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          if (mem_ack) begin
            lo          <= mem_data;
            mem_addr[0] <= 1'b1;
            state       <= RD_HI;
          end
        end
        RD_HI: begin
          if (mem_ack) begin
            hi      <= mem_data;
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          rom_data <= {hi, lo};
          rom_ack  <= req_seen;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_tc0100scn_rom_fetch.sv
// Scoreboard bench for tc0100scn_rom_fetch with a latency-programmable arbiter and ROM model.
module tb_tc0100scn_rom_fetch;

`ifdef TC0100SCN_ROM_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [20:0] rom_address;
  logic        rom_req;
  logic [31:0] rom_data;
  logic        rom_ack;
  logic [19:0] mem_addr;
  logic        mem_req;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic        cache_inval;

  tc0100scn_rom_fetch #(.ADDR_W(21)) dut (
    .clk(clk), .reset(reset), .rom_address(rom_address), .rom_req(rom_req),
    .rom_data(rom_data), .rom_ack(rom_ack), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_data(mem_data), .mem_ack(mem_ack), .cache_inval(cache_inval)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] data;
    logic        ack;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned addr_q[$];
  logic [15:0] rom_ovr[int unsigned];
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned arb_lat  = 1;
  logic        mon_last = 1'b0;

  // Reference cache: last word-aligned byte address and its 32-bit row.
  bit          cv = 1'b0;
  int unsigned ctag = 0;
  logic [31:0] cdata = '0;

  function automatic logic [15:0] rom_rd(input int unsigned wa);
    logic [31:0] h;
    int unsigned w;
    w = wa & 32'hF_FFFF;
    if (rom_ovr.exists(w)) return rom_ovr[w];
    h = w * 32'h9E37_79B1;
    return h[23:8];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_req(input logic [20:0] addr, input logic phase, output bit hit);
    int unsigned a, wa;
    logic [31:0] d;
    a   = int'(addr) & ~32'd3;
    wa  = a >> 1;
    hit = CACHE_EN && cv && (ctag == a);
    d   = hit ? cdata : {rom_rd(wa + 1), rom_rd(wa)};
    sb_q.push_back('{data: d, ack: phase});
    if (!hit) begin
      addr_q.push_back(wa);
      addr_q.push_back(wa + 1);
      if (CACHE_EN) begin
        cv = 1'b1;
        ctag = a;
        cdata = d;
      end
    end
  endtask

  task automatic do_req(input logic [20:0] addr, input int unsigned lat);
    bit hit, saw_req;
    int unsigned n;
    arb_lat = lat;
    rom_address = addr;
    rom_req = ~rom_req;
    expect_req(addr, rom_req, hit);
    n = 0;
    saw_req = 1'b0;
    while (rom_ack != rom_req && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (mem_req) saw_req = 1'b1;
    end
    check("latency", 64'(n), hit ? 64'd2 : 64'(2 + 2 * lat));
    if (hit) check("hit_no_mem_req", 64'(saw_req), 64'd0);
  endtask

  task automatic inval();
    cache_inval = 1'b1;
    @(posedge clk); #1;
    cache_inval = 1'b0;
    cv = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (rom_ack != rom_req && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("ack_matches_req", 64'(rom_ack), 64'(rom_req));
  endtask

  // Arbiter: each word completes arb_lat cycles after it starts; a read already
  // launched still acks even if the request is withdrawn meanwhile.
  initial begin
    bit          active;
    int unsigned cnt;
    int unsigned start_addr;
    active = 1'b0;
    cnt = 0;
    start_addr = 0;
    mem_ack = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
        active = mem_req;
      end else if (!active && mem_req) begin
        active = 1'b1;
        cnt = 0;
      end
      mem_data = 16'($urandom);
      if (active) begin
        cnt++;
        if (cnt == 1) start_addr = int'(mem_addr);
        if (cnt >= arb_lat) begin
          mem_ack = 1'b1;
          if (mem_req) begin
            mem_data = rom_rd(int'(mem_addr));
            check("mem_addr_steady", 64'(mem_addr), 64'(start_addr));
            if (addr_q.size() == 0) check("mem_addr_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
            else check("mem_addr_seq", 64'(mem_addr), 64'(addr_q.pop_front()));
          end else begin
            mem_data = ~rom_rd(start_addr);
          end
        end
      end
    end
  end

  // Monitor: every rom_ack transition is one completion to score.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rom_ack != mon_last) begin
        mon_last = rom_ack;
        if (sb_q.size() == 0) begin
          check("unexpected_completion", 64'(rom_data), 64'hFFFF_FFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("rom_data", 64'(rom_data), 64'(e.data));
          check("rom_ack_phase", 64'(rom_ack), 64'(e.ack));
        end
      end
    end
  end

  initial begin
    bit          hit;
    int unsigned n;
    logic [20:0] a, last_a;

    reset = 1'b1;
    rom_address = '0;
    rom_req = 1'b0;
    cache_inval = 1'b0;
    rom_ovr[32'h80] = 16'h1111;
    rom_ovr[32'h81] = 16'h2222;
    repeat (4) @(posedge clk);
    #1;
    check("reset_rom_data", 64'(rom_data), 64'd0);
    check("reset_rom_ack", 64'(rom_ack), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_req(21'h00100, 1);
    // Changed ROM behind a valid entry exposes whether the row came from the cache.
    rom_ovr[32'h80] = 16'h3333;
    do_req(21'h00100, 1);
    inval();
    do_req(21'h00100, 1);
    do_req(21'h0010F, 1);

    // Second toggle lands while the first fetch is still reading its low word.
    arb_lat = 3;
    rom_address = 21'h00300;
    rom_req = ~rom_req;
    expect_req(21'h00300, rom_req, hit);
    @(posedge clk); #1;
    rom_address = 21'h00200;
    rom_req = ~rom_req;
    expect_req(21'h00200, rom_req, hit);
    wait_done();

    // Reset while the high word is outstanding; its ack arrives after reset.
    if (rom_req) do_req(21'h00500, 1);
    arb_lat = 2;
    rom_address = 21'h00400;
    rom_req = 1'b1;
    expect_req(21'h00400, 1'b1, hit);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_mem_req", 64'(mem_req), 64'd0);
    check("rst_mid_rom_ack", 64'(rom_ack), 64'd0);
    check("rst_mid_rom_data", 64'(rom_data), 64'd0);
    reset = 1'b0;
    sb_q.delete();
    addr_q.delete();
    cv = 1'b0;
    mon_last = 1'b0;
    expect_req(21'h00400, 1'b1, hit);
    n = 0;
    while (rom_ack != rom_req && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("post_reset_latency", 64'(n), 64'd6);

    do_req(21'h008A0, 6);

    last_a = 21'h00100;
    for (int unsigned i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) rom_ovr[32'h40 + $urandom_range(0, 15)] = 16'($urandom);
      if ($urandom_range(0, 4) == 0) inval();
      case ($urandom_range(0, 2))
        0:       a = last_a;
        1:       a = 21'(32'h80 + $urandom_range(0, 31));
        default: a = 21'($urandom);
      endcase
      do_req(a, $urandom_range(1, 6));
      last_a = a;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("addr_queue_drained", 64'(addr_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
